mmu_l1_tlb: RTL
===============

// Module: mmu_l1_tlb
// PURPOSE
// Fully associative first-level TLB that translates one VPN at a time for a core port (fetch or data).
// Sits directly upstream of the page-table walker: on a miss it issues a walk request, fills from the walk response, then answers.
// Supports Sv39-style superpages (level 0 = largest), A/D handling and a global flush.
// PARAMETERS
// ENTRIES        8   number of TLB entries (power of 2, >=2)
// LEVELS         3   page-table levels
// PAGE_LVL_BITS  9   VPN bits per level
// VPN_SIZE       27  LEVELS*PAGE_LVL_BITS
// PPN_SIZE       44  physical page number width
// PORTS
// clk_i             in   1                  clock
// rstn_i            in   1                  reset, asynchronous, active-low
// req_valid_i       in   1                  translation request
// req_ready_o       out  1                  block idle, request accepted when valid&ready
// req_vpn_i         in   VPN_SIZE           virtual page number
// req_store_i       in   1                  store access
// req_fetch_i       in   1                  instruction fetch (store ignored if set)
// req_prv_i         in   2                  privilege: 0=U, 1=S (others treated as S)
// sum_i             in   1                  mstatus.SUM
// flush_i           in   1                  invalidate all entries
// resp_valid_o      out  1                  one-cycle response pulse
// resp_ppn_o        out  PPN_SIZE           translated PPN (0 when resp_xcpt_o)
// resp_xcpt_o       out  1                  page fault
// ptw_req_valid_o   out  1                  walk request
// ptw_ready_i       in   1                  walker ready; request taken when valid&ready
// ptw_req_vpn_o     out  VPN_SIZE           walk VPN (+ ptw_req_store_o, ptw_req_fetch_o, ptw_req_prv_o [2] mirror latched request)
// ptw_resp_valid_i  in   1                  walk done
// ptw_resp_error_i  in   1                  walk failed
// ptw_resp_level_i  in   $clog2(LEVELS)     leaf level
// ptw_resp_ppn_i    in   PPN_SIZE           leaf PPN (low bits already merged with VPN)
// ptw_resp_perm_i   in   8                  {d,a,g,u,x,w,r,v}
// pmu_hit_o, pmu_miss_o  out 1              one-cycle pulses per first lookup hit/miss
// BEHAVIOUR
// Reset: state IDLE, all entries invalid, victim ptr 0, every output 0 except req_ready_o=1.
// FSM: IDLE -> LOOKUP -> {RESP | PTW_REQ -> PTW_WAIT -> LOOKUP | RESP} ; RESP -> IDLE.
// - IDLE: req_ready_o=1; on accept latch vpn/store/fetch/prv/sum, go LOOKUP.
// - LOOKUP: entry i hits if valid and vpn[VPN_SIZE-1 -: (level_i+1)*PAGE_LVL_BITS] matches; hits qualified by !flush_i.
//   Hit, store, entry d=0: invalidate entry, treat as miss (walker sets D). Otherwise hit -> RESP.
//   Miss -> PTW_REQ. pmu pulses only on the first LOOKUP of a request, not the post-fill re-lookup.
// - PTW_REQ: ptw_req_valid_o=1, held stable until ptw_ready_i; then PTW_WAIT.
// - PTW_WAIT: on ptw_resp_valid_i: error -> RESP with xcpt=1, no fill; else fill entry, go LOOKUP.
//   Fill target: lowest-index invalid entry, else victim ptr; ptr increments (wraps) on every fill.
//   flush_i seen anywhere in PTW_REQ/PTW_WAIT (incl. response cycle) sets drop flag: response not filled, LOOKUP misses, walk repeats.
// - RESP: resp_valid_o=1 for exactly one cycle; ppn/xcpt registered; back to IDLE.
// Hit latency: accept at edge N, resp_valid_o high in cycle N+2. Miss adds walk latency + 1 re-lookup cycle.
// PPN: level L < LEVELS-1 -> low (LEVELS-1-L)*PAGE_LVL_BITS bits taken from request VPN, rest from entry.
// Permission fault (resp_xcpt_o=1) if: !v; or !a; fetch && !x; load && !r; store && !w;
//   prv=U && !u; prv=S && u && (fetch || !sum).
// flush_i: all valid bits clear next edge; flush beats a same-cycle fill. No duplicates (fill only after miss).
// Mid-operation reset: asynchronous return to reset state; in-flight walk response discarded.
// TESTING
// 1 Reset, load vpn=0x123 -> miss, ptw_req_valid_o with vpn 0x123; resp ppn=0x456 perm=0x4F lvl=2 -> resp_ppn_o=0x456, xcpt=0, pmu_miss=1.
// 2 Repeat vpn=0x123 load -> ptw_req_valid_o stays 0, resp_valid_o 2 cycles after accept, pmu_hit=1.
// 3 Superpage lvl=1 ppn=0x200 for vpn=0x00400; then vpn=0x004AB -> hit, resp_ppn_o=0x2AB.
// 4 Store to entry with d=0 -> entry invalidated, new walk issued; perm=0xCF fill -> xcpt=0.
// 5 U-page (u=1) S-load with sum=0 -> xcpt=1, ppn=0; same with sum=1 -> xcpt=0; S-fetch -> xcpt=1.
// 6 Fill 9 distinct VPNs with ENTRIES=8 -> 9th evicts entry 0; flush_i during PTW_WAIT -> response dropped, second walk issued.

Source files
------------

// File: rtl/mmu_l1_tlb.sv
// Fully associative L1 TLB with Sv39-style superpages, A/D permission checks and
// page-table-walker refill. One translation is in flight at a time.
module mmu_l1_tlb #(
  parameter int  ENTRIES       = 8,
  parameter int  LEVELS        = 3,
  parameter int  PAGE_LVL_BITS = 9,
  parameter int  VPN_SIZE      = LEVELS * PAGE_LVL_BITS,
  parameter int  PPN_SIZE      = 44,
  localparam int LVL_W         = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int IDX_W         = $clog2(ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [VPN_SIZE-1:0] req_vpn_i,
  input  logic                req_store_i,
  input  logic                req_fetch_i,
  input  logic [1:0]          req_prv_i,
  input  logic                sum_i,
  input  logic                flush_i,
  output logic                resp_valid_o,
  output logic [PPN_SIZE-1:0] resp_ppn_o,
  output logic                resp_xcpt_o,
  output logic                ptw_req_valid_o,
  input  logic                ptw_ready_i,
  output logic [VPN_SIZE-1:0] ptw_req_vpn_o,
  output logic                ptw_req_store_o,
  output logic                ptw_req_fetch_o,
  output logic [1:0]          ptw_req_prv_o,
  input  logic                ptw_resp_valid_i,
  input  logic                ptw_resp_error_i,
  input  logic [LVL_W-1:0]    ptw_resp_level_i,
  input  logic [PPN_SIZE-1:0] ptw_resp_ppn_i,
  input  logic [7:0]          ptw_resp_perm_i,
  output logic                pmu_hit_o,
  output logic                pmu_miss_o
);

  localparam int P_V = 0, P_R = 1, P_W = 2, P_X = 3, P_U = 4, P_G = 5, P_A = 6, P_D = 7;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_PTW_REQ, S_PTW_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [VPN_SIZE-1:0] req_vpn_q;
  logic                req_store_q, req_fetch_q, req_sum_q;
  logic [1:0]          req_prv_q;
  logic                relookup_q, drop_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [IDX_W-1:0]    victim_q;
  logic [PPN_SIZE-1:0] resp_ppn_q;
  logic                resp_xcpt_q, pmu_hit_q, pmu_miss_q;

  logic [VPN_SIZE-1:0] tag_vpn_q  [ENTRIES];
  logic [LVL_W-1:0]    tag_lvl_q  [ENTRIES];
  logic [PPN_SIZE-1:0] tag_ppn_q  [ENTRIES];
  logic [7:0]          tag_perm_q [ENTRIES];

  logic [ENTRIES-1:0]  hit_vec;
  logic [IDX_W-1:0]    hit_idx, fill_idx;
  logic                hit_any, dirty_miss, lookup_hit, perm_fault;
  logic                is_store, is_load, req_accept, walk_done, drop_now, fill;
  logic [7:0]          hit_perm;
  logic [VPN_SIZE-1:0] hit_off_mask;
  logic [PPN_SIZE-1:0] hit_ppn;
  logic                unused_perm_g;

  // Mask of the VPN bits that lie inside the page offset of a leaf at level lvl.
  function automatic logic [VPN_SIZE-1:0] page_off_mask(input logic [LVL_W-1:0] lvl);
    int shamt;
    shamt = (int'(lvl) >= LEVELS - 1) ? 0 : (LEVELS - 1 - int'(lvl)) * PAGE_LVL_BITS;
    return ~({VPN_SIZE{1'b1}} << shamt);
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      hit_vec[i] = valid_q[i] && (((tag_vpn_q[i] ^ req_vpn_q) & ~page_off_mask(tag_lvl_q[i])) == '0);
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    hit_any      = (|hit_vec) && !flush_i;
    hit_perm     = tag_perm_q[hit_idx];
    hit_off_mask = page_off_mask(tag_lvl_q[hit_idx]);
    hit_ppn      = (tag_ppn_q[hit_idx] & ~PPN_SIZE'(hit_off_mask))
                 | (PPN_SIZE'(req_vpn_q) & PPN_SIZE'(hit_off_mask));
  end

  assign unused_perm_g = hit_perm[P_G];
  assign is_store   = req_store_q && !req_fetch_q;
  assign is_load    = !req_store_q && !req_fetch_q;
  // A clean page must be re-walked on a store so the walker can set D.
  assign dirty_miss = hit_any && is_store && !hit_perm[P_D];
  assign lookup_hit = hit_any && !dirty_miss;

  assign perm_fault = !hit_perm[P_V] || !hit_perm[P_A]
                   || (req_fetch_q && !hit_perm[P_X])
                   || (is_load && !hit_perm[P_R])
                   || (is_store && !hit_perm[P_W])
                   || ((req_prv_q == 2'd0) ? !hit_perm[P_U]
                                           : (hit_perm[P_U] && (req_fetch_q || !req_sum_q)));

  always_comb begin
    fill_idx = victim_q;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid_q[i]) fill_idx = IDX_W'(i);
  end

  assign req_accept = (state_q == S_IDLE) && req_valid_i;
  assign walk_done  = (state_q == S_PTW_WAIT) && ptw_resp_valid_i;
  assign drop_now   = drop_q || flush_i;
  assign fill       = walk_done && !ptw_resp_error_i && !drop_now;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (req_valid_i) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = lookup_hit ? S_RESP : S_PTW_REQ;
      S_PTW_REQ:  if (ptw_ready_i) state_d = S_PTW_WAIT;
      S_PTW_WAIT: if (ptw_resp_valid_i)
                    state_d = (ptw_resp_error_i && !drop_now) ? S_RESP : S_LOOKUP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = 1'b0;
    ptw_req_valid_o = 1'b0;
    resp_valid_o    = 1'b0;
    unique case (state_q)
      S_IDLE:    req_ready_o     = 1'b1;
      S_PTW_REQ: ptw_req_valid_o = 1'b1;
      S_RESP:    resp_valid_o    = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_vpn_q   <= '0;
      req_store_q <= 1'b0;
      req_fetch_q <= 1'b0;
      req_prv_q   <= '0;
      req_sum_q   <= 1'b0;
      relookup_q  <= 1'b0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
      victim_q    <= '0;
      resp_ppn_q  <= '0;
      resp_xcpt_q <= 1'b0;
      pmu_hit_q   <= 1'b0;
      pmu_miss_q  <= 1'b0;
    end else begin
      pmu_hit_q  <= 1'b0;
      pmu_miss_q <= 1'b0;
      if (req_accept) begin
        req_vpn_q   <= req_vpn_i;
        req_store_q <= req_store_i;
        req_fetch_q <= req_fetch_i;
        req_prv_q   <= req_prv_i;
        req_sum_q   <= sum_i;
        relookup_q  <= 1'b0;
      end
      if (state_q == S_LOOKUP) begin
        pmu_hit_q  <= !relookup_q && lookup_hit;
        pmu_miss_q <= !relookup_q && !lookup_hit;
        if (lookup_hit) begin
          resp_xcpt_q <= perm_fault;
          resp_ppn_q  <= perm_fault ? '0 : hit_ppn;
        end
      end
      // A flush during the walk makes its result stale; the walk is repeated.
      if ((state_q == S_PTW_REQ || state_q == S_PTW_WAIT) && flush_i) drop_q <= 1'b1;
      if (walk_done) begin
        drop_q     <= 1'b0;
        relookup_q <= 1'b1;
        if (ptw_resp_error_i && !drop_now) begin
          resp_xcpt_q <= 1'b1;
          resp_ppn_q  <= '0;
        end
      end
      if (flush_i)                                   valid_q           <= '0;
      else if (fill)                                 valid_q[fill_idx] <= 1'b1;
      else if (state_q == S_LOOKUP && dirty_miss)    valid_q[hit_idx]  <= 1'b0;
      if (fill) victim_q <= victim_q + IDX_W'(1);
    end
  end

  // NOTE: entry payload is never reset; valid_q alone decides whether it is ever used.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_vpn_q[fill_idx]  <= req_vpn_q;
      tag_lvl_q[fill_idx]  <= ptw_resp_level_i;
      tag_ppn_q[fill_idx]  <= ptw_resp_ppn_i;
      tag_perm_q[fill_idx] <= ptw_resp_perm_i;
    end
  end

  assign resp_ppn_o      = resp_ppn_q;
  assign resp_xcpt_o     = resp_xcpt_q;
  assign ptw_req_vpn_o   = req_vpn_q;
  assign ptw_req_store_o = req_store_q;
  assign ptw_req_fetch_o = req_fetch_q;
  assign ptw_req_prv_o   = req_prv_q;
  assign pmu_hit_o       = pmu_hit_q;
  assign pmu_miss_o      = pmu_miss_q;

endmodule
